// File: rtl/sound_pkg.sv
// Shared types and default geometry for the sound RAM arbiter.
// Holds the FSM state encoding and the default slot timing.
// Imported by the slot timer and the arbiter top.
package sound_pkg;

  localparam int SOUND_ADDR_W      = 16;
  localparam int SOUND_DATA_W      = 8;
  localparam int SOUND_SLOT_CYCLES = 32;
  localparam int SOUND_DOC_PHASE   = 0;
  localparam int SOUND_HOST_PHASE  = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DOC_ISSUE  = 3'd1,
    ST_DOC_DATA   = 3'd2,
    ST_HOST_ISSUE = 3'd3,
    ST_HOST_DATA  = 3'd4
  } state_t;

endpackage

// File: rtl/sound_slot_timer.sv
// Free-running DOC-cycle phase counter with per-slot strobes.
// Strobes are combinational from the phase register (high for one clock per period).
// No backpressure: the counter never stalls.
module sound_slot_timer
  import sound_pkg::*;
#(
  parameter int SLOT_CYCLES = SOUND_SLOT_CYCLES,
  parameter int DOC_PHASE   = SOUND_DOC_PHASE,
  parameter int HOST_PHASE  = SOUND_HOST_PHASE
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [$clog2(SLOT_CYCLES)-1:0] phase,
  output logic                           doc_slot,
  output logic                           host_slot
);

  localparam int PW = $clog2(SLOT_CYCLES);
  localparam logic [PW-1:0] LAST_P = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] DOC_P  = PW'(DOC_PHASE);
  localparam logic [PW-1:0] HOST_P = PW'(HOST_PHASE);

  // Phase advances every clock and wraps at the end of the DOC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (phase == LAST_P) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign doc_slot  = (phase == DOC_P);
  assign host_slot = (phase == HOST_P);

endmodule

// File: rtl/sound_ram_arbiter.sv
// Time-slot arbiter sharing the sound RAM between DOC fetches and GLU host accesses.
// Latency: DOC/host result 2 edges after the issuing slot edge; host worst case SLOT_CYCLES+3.
// Host requests while host_busy are dropped; optional SOUND_RAM_SLOT_STEAL_EN lets the host use an idle DOC slot.
module sound_ram_arbiter
  import sound_pkg::*;
#(
  parameter int ADDR_W      = SOUND_ADDR_W,
  parameter int DATA_W      = SOUND_DATA_W,
  parameter int SLOT_CYCLES = SOUND_SLOT_CYCLES,
  parameter int DOC_PHASE   = SOUND_DOC_PHASE,
  parameter int HOST_PHASE  = SOUND_HOST_PHASE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           doc_req,
  input  logic [ADDR_W-1:0]              doc_addr,
  output logic                           doc_rvalid,
  output logic [DATA_W-1:0]              doc_rdata,
  input  logic                           host_req,
  input  logic                           host_we,
  input  logic [ADDR_W-1:0]              host_addr,
  input  logic [DATA_W-1:0]              host_wdata,
  output logic                           host_busy,
  output logic                           host_ack,
  output logic [DATA_W-1:0]              host_rdata,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_wdata,
  input  logic [DATA_W-1:0]              ram_rdata,
  output logic [$clog2(SLOT_CYCLES)-1:0] slot_phase
);

  logic doc_slot;
  logic host_slot;

  sound_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .DOC_PHASE   (DOC_PHASE),
    .HOST_PHASE  (HOST_PHASE)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .phase     (slot_phase),
    .doc_slot  (doc_slot),
    .host_slot (host_slot)
  );

  state_t              state, state_d;
  logic                pending, pending_d;
  logic                busy_d;
  logic                lat_we, lat_we_d;
  logic [ADDR_W-1:0]   lat_addr, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata, lat_wdata_d;
  logic                ram_en_d, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_d;
  logic                doc_rvalid_d, host_ack_d;
  logic [DATA_W-1:0]   doc_rdata_d, host_rdata_d;
  logic                steal_ok;

  // Host may borrow the DOC slot only when the feature is built in and the DOC passes.
`ifdef SOUND_RAM_SLOT_STEAL_EN
  assign steal_ok = doc_slot && !doc_req;
`else
  assign steal_ok = 1'b0;
`endif

  // Next-state and next-output decode; strobes default low, data outputs hold.
  always_comb begin
    state_d      = state;
    pending_d    = pending;
    busy_d       = host_busy;
    lat_we_d     = lat_we;
    lat_addr_d   = lat_addr;
    lat_wdata_d  = lat_wdata;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    doc_rvalid_d = 1'b0;
    doc_rdata_d  = doc_rdata;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata;

    // A new host request is only accepted when nothing is outstanding; the
    // pending register seen here is the pre-edge value, so a request captured
    // on the host slot edge cannot be issued on that same edge.
    if (host_req && !host_busy) begin
      busy_d      = 1'b1;
      pending_d   = 1'b1;
      lat_we_d    = host_we;
      lat_addr_d  = host_addr;
      lat_wdata_d = host_wdata;
    end

    case (state)
      ST_IDLE: begin
        if (doc_slot && doc_req) begin
          ram_en_d   = 1'b1;
          ram_addr_d = doc_addr;
          state_d    = ST_DOC_ISSUE;
        end else if (pending && (host_slot || steal_ok)) begin
          ram_en_d    = 1'b1;
          ram_we_d    = lat_we;
          ram_addr_d  = lat_addr;
          ram_wdata_d = lat_wdata;
          pending_d   = 1'b0;
          state_d     = ST_HOST_ISSUE;
        end
      end
      ST_DOC_ISSUE: begin
        state_d = ST_DOC_DATA;
      end
      ST_DOC_DATA: begin
        doc_rvalid_d = 1'b1;
        doc_rdata_d  = ram_rdata;
        state_d      = ST_IDLE;
      end
      ST_HOST_ISSUE: begin
        state_d = ST_HOST_DATA;
      end
      ST_HOST_DATA: begin
        host_ack_d = 1'b1;
        busy_d     = 1'b0;
        if (!lat_we) begin
          host_rdata_d = ram_rdata;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      host_busy  <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      doc_rvalid <= 1'b0;
      doc_rdata  <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      state      <= state_d;
      pending    <= pending_d;
      host_busy  <= busy_d;
      lat_we     <= lat_we_d;
      lat_addr   <= lat_addr_d;
      lat_wdata  <= lat_wdata_d;
      ram_en     <= ram_en_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      doc_rvalid <= doc_rvalid_d;
      doc_rdata  <= doc_rdata_d;
      host_ack   <= host_ack_d;
      host_rdata <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Bench for sound_ram_arbiter: 1-cycle-read RAM model, phase model, slot timing predicted from phase arithmetic.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// Honours SOUND_RAM_SLOT_STEAL_EN when predicting which slot serves the host.
module tb_sound_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SC = 32;
  localparam int DP = 0;
  localparam int HP = 16;
  localparam int PW = $clog2(SC);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          doc_req = 1'b0;
  logic [AW-1:0] doc_addr = '0;
  logic          doc_rvalid;
  logic [DW-1:0] doc_rdata;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_busy;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [PW-1:0] slot_phase;

  sound_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .SLOT_CYCLES(SC), .DOC_PHASE(DP), .HOST_PHASE(HP)
  ) dut (
    .clk(clk), .reset(reset),
    .doc_req(doc_req), .doc_addr(doc_addr), .doc_rvalid(doc_rvalid), .doc_rdata(doc_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .slot_phase(slot_phase)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with one-cycle read.
  logic [DW-1:0] mem [0:65535] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Expected phase: zero on a reset edge, otherwise count modulo SC.
  int mphase = 0;
  always @(posedge clk) begin
    if (reset) mphase <= 0;
    else       mphase <= (mphase + 1) % SC;
  end

  // Event counters sampled mid-cycle.
  int en_cnt = 0;
  int ack_cnt = 0;
  int we_wo_en = 0;
  always @(negedge clk) begin
    if (ram_en) en_cnt++;
    if (host_ack) ack_cnt++;
    if (ram_we && !ram_en) we_wo_en++;
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [0:65535] = '{default: 8'h00};
  logic [DW-1:0] exp_hrd = '0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < SC + 2 && mphase != p; i++) tick(1);
    checks++;
    if (slot_phase !== PW'(p)) begin
      errors++;
      $display("FAIL wait_phase slot_phase got %0d expected %0d", slot_phase, p);
    end
  endtask

  // Edges after the capture edge until the edge that issues the host access.
  function automatic int serve_dist(input int p, input logic dreq);
    for (int k = 1; k <= SC; k++) begin
      int ph;
      ph = (p + k) % SC;
      if (ph == HP) return k;
`ifdef SOUND_RAM_SLOT_STEAL_EN
      if (!dreq && ph == DP) return k;
`endif
    end
    return SC;
  endfunction

  // One host access requested while phase == p; checks issue, ack timing, data.
  task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int p, input logic dreq);
    int k, ack_at, en0;
    doc_req = dreq;
    wait_phase(p);
    k = serve_dist(p, dreq);
    en0 = en_cnt;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    tick(1);
    host_req = 1'b0; host_we = ~we; host_addr = AW'($urandom); host_wdata = DW'($urandom);
    checks++;
    if (host_busy !== 1'b1) begin
      errors++; $display("FAIL host_busy_set got %b expected 1", host_busy);
    end
    ack_at = -1;
    for (int n = 1; n <= k + 4; n++) begin
      tick(1);
      if (host_ack === 1'b1 && ack_at < 0) ack_at = n;
      if (n == k) begin
        checks++;
        if (ram_en !== 1'b1 || ram_we !== we || ram_addr !== a || (we && ram_wdata !== d)) begin
          errors++;
          $display("FAIL host_issue en=%b we=%b addr=%h wdata=%h expected en=1 we=%b addr=%h wdata=%h",
                   ram_en, ram_we, ram_addr, ram_wdata, we, a, d);
        end
      end
      if (n == k + 2) begin
        if (we) ref_mem[a] = d;
        else    exp_hrd = ref_mem[a];
        checks++;
        if (host_busy !== 1'b0 || host_rdata !== exp_hrd) begin
          errors++;
          $display("FAIL host_done busy=%b rdata=%h expected busy=0 rdata=%h", host_busy, host_rdata, exp_hrd);
        end
      end
    end
    checks++;
    if (ack_at != k + 2) begin
      errors++; $display("FAIL host_ack_time got %0d expected %0d", ack_at, k + 2);
    end
    if (!dreq) begin
      checks++;
      if (en_cnt - en0 != 1) begin
        errors++; $display("FAIL host_single_access got %0d expected 1", en_cnt - en0);
      end
    end
  endtask

  task automatic test_reset();
    int wraps;
    logic [PW-1:0] prev;
    reset = 1'b1;
    tick(3);
    checks++;
    if ({ram_en, ram_we, doc_rvalid, host_ack, host_busy} !== 5'b0 || slot_phase !== '0) begin
      errors++; $display("FAIL reset_strobes got %b phase %0d expected 0", {ram_en, ram_we, doc_rvalid, host_ack, host_busy}, slot_phase);
    end
    checks++;
    if (doc_rdata !== '0 || host_rdata !== '0 || ram_addr !== '0 || ram_wdata !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h expected 0", doc_rdata, host_rdata, ram_addr, ram_wdata);
    end
    reset = 1'b0;
    wraps = 0;
    prev = slot_phase;
    for (int i = 0; i < 70; i++) begin
      tick(1);
      checks++;
      if (slot_phase !== PW'(mphase) || {ram_en, doc_rvalid, host_ack, host_busy} !== 4'b0) begin
        errors++; $display("FAIL idle_cycle %0d phase %0d expected %0d outs %b", i, slot_phase, mphase, {ram_en, doc_rvalid, host_ack, host_busy});
      end
      if (prev == PW'(SC - 1) && slot_phase == '0) wraps++;
      prev = slot_phase;
    end
    checks++;
    if (wraps != 2) begin
      errors++; $display("FAIL phase_wraps got %0d expected 2", wraps);
    end
  endtask

  task automatic test_doc();
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    for (int it = 0; it < 4; it++) begin
      a = (it == 0) ? 16'h1234 : AW'($urandom);
      v = (it == 0) ? 8'h5A : DW'($urandom);
      host_access(1'b1, a, v, 3, 1'b0);
      for (int rep = 0; rep < 2; rep++) begin
        doc_addr = a;
        doc_req = 1'b1;
        wait_phase(DP);
        tick(1);
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== a) begin
          errors++; $display("FAIL doc_issue en=%b we=%b addr=%h expected 1 0 %h", ram_en, ram_we, ram_addr, a);
        end
        tick(1);
        checks++;
        if (ram_en !== 1'b0 || doc_rvalid !== 1'b0) begin
          errors++; $display("FAIL doc_gap en=%b rvalid=%b expected 0 0", ram_en, doc_rvalid);
        end
        tick(1);
        checks++;
        if (doc_rvalid !== 1'b1 || doc_rdata !== ref_mem[a]) begin
          errors++; $display("FAIL doc_data rvalid=%b data=%h expected 1 %h", doc_rvalid, doc_rdata, ref_mem[a]);
        end
        tick(1);
        checks++;
        if (doc_rvalid !== 1'b0) begin
          errors++; $display("FAIL doc_pulse rvalid=%b expected 0", doc_rvalid);
        end
      end
    end
    doc_req = 1'b0;
  endtask

  task automatic test_host_write_read();
    logic [AW-1:0] pool [4];
    host_access(1'b1, 16'h00FF, 8'hA5, 3, 1'b0);
    host_access(1'b0, 16'h00FF, 8'h00, 3, 1'b0);
    for (int i = 0; i < 4; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 14; i++) begin
      host_access(1'($urandom), pool[$urandom_range(0, 3)], DW'($urandom),
                  int'($urandom_range(0, SC - 1)), 1'($urandom));
    end
    doc_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k, ack_at, en0, cnt_after;
    logic [AW-1:0] a1;
    a1 = AW'($urandom);
    doc_req = 1'b0;
    wait_phase(HP);
    k = serve_dist(HP, 1'b0);
    en0 = en_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = a1;
    tick(1);
    host_req = 1'b0;
    ack_at = -1;
    for (int n = 1; n <= k + 4; n++) begin
      if (n == 5) begin
        host_req = 1'b1; host_we = 1'b1; host_addr = ~a1; host_wdata = DW'($urandom);
      end
      tick(1);
      host_req = 1'b0;
      if (host_ack === 1'b1 && ack_at < 0) ack_at = n;
      if (n == k) begin
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== a1) begin
          errors++; $display("FAIL missed_slot_issue en=%b we=%b addr=%h expected 1 0 %h", ram_en, ram_we, ram_addr, a1);
        end
      end
    end
    exp_hrd = ref_mem[a1];
    checks++;
    if (ack_at != k + 2) begin
      errors++; $display("FAIL missed_slot_ack got %0d expected %0d", ack_at, k + 2);
    end
    tick(40);
    cnt_after = en_cnt - en0;
    checks++;
    if (cnt_after != 1) begin
      errors++; $display("FAIL ignored_req_accesses got %0d expected 1", cnt_after);
    end
  endtask

  task automatic test_reset_mid();
    int k, en0, ack0;
    doc_req = 1'b0;
    wait_phase(10);
    k = serve_dist(10, 1'b0);
    host_req = 1'b1; host_we = 1'b0; host_addr = AW'($urandom);
    tick(1);
    host_req = 1'b0;
    tick(k);
    checks++;
    if (ram_en !== 1'b1) begin
      errors++; $display("FAIL reset_mid_issue en=%b expected 1", ram_en);
    end
    ack0 = ack_cnt;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_hrd = '0;
    checks++;
    if (ram_en !== 1'b0 || host_busy !== 1'b0 || host_ack !== 1'b0 || host_rdata !== '0) begin
      errors++; $display("FAIL reset_mid_state en=%b busy=%b ack=%b rdata=%h expected 0", ram_en, host_busy, host_ack, host_rdata);
    end
    en0 = en_cnt;
    tick(40);
    checks++;
    if (ack_cnt != ack0 || en_cnt != en0 || host_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_dropped acks=%0d accesses=%0d busy=%b expected 0 0 0", ack_cnt - ack0, en_cnt - en0, host_busy);
    end
  endtask

  task automatic test_slot_steal();
    host_access(1'b1, 16'h0400, 8'h3C, 20, 1'b0);
    host_access(1'b0, 16'h0400, 8'h00, 20, 1'b0);
    host_access(1'b0, 16'h0400, 8'h00, 20, 1'b1);
    doc_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_doc();
    test_host_write_read();
    test_back_to_back();
    test_reset_mid();
    test_slot_steal();
    checks++;
    if (we_wo_en != 0) begin
      errors++; $display("FAIL ram_we_without_en got %0d expected 0", we_wo_en);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_ram_arbiter.md
Name: sound_ram_arbiter

Overview:
Time-slot arbiter for the 64 KB sound RAM, shared between the DOC oscillator fetch engine and the GLU host port (SNDDATA RAM accesses). A free-running phase counter divides each DOC cycle into SLOT_CYCLES clocks. The DOC owns a fixed read slot and the host owns a fixed read/write slot. The block drives the single-port synchronous RAM and returns data and acknowledges to each requester.

Parameters:
ADDR_W, 16, sound RAM address width
DATA_W, 8, sound RAM data width
SLOT_CYCLES, 32, clocks per DOC cycle; phase counter modulus (at least 8)
DOC_PHASE, 0, phase value at which the DOC slot starts
HOST_PHASE, 16, phase value at which the host slot starts; absolute distance from DOC_PHASE (mod SLOT_CYCLES) is at least 4

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
doc_req  in  1  DOC wants a fetch this DOC cycle (level)
doc_addr  in  ADDR_W  DOC fetch address
doc_rvalid  out  1  one-cycle pulse: doc_rdata valid
doc_rdata  out  DATA_W  fetched byte
host_req  in  1  one-cycle request pulse from GLU
host_we  in  1  1 = write, 0 = read; sampled with host_req
host_addr  in  ADDR_W  sampled with host_req
host_wdata  in  DATA_W  sampled with host_req
host_busy  out  1  host request pending or in flight
host_ack  out  1  one-cycle pulse: host access complete
host_rdata  out  DATA_W  read data; valid with host_ack, held until the next host read
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write strobe; only ever high together with ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data; valid the cycle after RAM samples ram_en
slot_phase  out  $clog2(SLOT_CYCLES)  current phase, for debug and for DOC timing

Behaviour:
- Reset: phase = 0, state = ST_IDLE, pending cleared. All outputs 0, including ram_en/ram_we, doc_rvalid, host_ack, host_busy, doc_rdata, host_rdata, ram_addr, ram_wdata.
- Phase counter: increments every clk. Wraps from SLOT_CYCLES-1 to 0.
- Host capture: at an edge where host_req=1 and host_busy=0, latch we, addr and wdata, and set host_busy. A host_req while host_busy=1 is ignored; no second access occurs.
- Slot decisions use register values seen at the deciding edge. A host_req captured at the HOST_PHASE edge misses that slot and is served one full period later.
- FSM states: ST_IDLE, ST_DOC_ISSUE, ST_DOC_DATA, ST_HOST_ISSUE, ST_HOST_DATA.
- IDLE, phase == DOC_PHASE, doc_req=1 (edge E0):
  - ram_en=1, ram_we=0, ram_addr=doc_addr; go to ST_DOC_ISSUE.
  - E1: ram_en=0; go to ST_DOC_DATA.
  - E2: doc_rdata=ram_rdata, doc_rvalid=1 for one cycle; go to ST_IDLE.
- IDLE, phase == HOST_PHASE, pending (E0):
  - ram_en=1, ram_we=host_we, ram_addr and ram_wdata from the latch; go to ST_HOST_ISSUE.
  - E1: ram_en/ram_we = 0; go to ST_HOST_DATA.
  - E2: host_ack=1 for one cycle, host_busy=0; host_rdata=ram_rdata on reads only; go to ST_IDLE.
- Latency: doc_rvalid and host_ack go high 2 edges after the issuing edge. Worst-case host latency is SLOT_CYCLES + 3 clocks.
- doc_req low at DOC_PHASE: the slot is unused (see Optional Feature).
- The DOC and host slots never overlap; the parameter constraints guarantee this.
- Reset mid-access: in-flight access is abandoned, with no doc_rvalid or host_ack. Pending host request is dropped. ram_en clears on the reset edge.

Optional Feature:
SOUND_RAM_SLOT_STEAL_EN
- Defined: in ST_IDLE at phase == DOC_PHASE with doc_req=0 and a host request pending, the host is served in the DOC slot with identical sequencing. The request is not repeated at HOST_PHASE.
- Undefined: the host is served only at HOST_PHASE.

Decomposition:
- Package sound_pkg holds:
  - state enum (ST_IDLE … ST_HOST_DATA)
  - default SLOT_CYCLES/DOC_PHASE/HOST_PHASE constants
  - SOUND_ADDR_W = 16, SOUND_DATA_W = 8
- Sub-module sound_slot_timer: phase counter plus one-cycle doc_slot/host_slot strobes. The arbiter FSM consumes the strobes.

Test Plan:
(Defaults: SLOT_CYCLES=32, DOC_PHASE=0, HOST_PHASE=16; RAM model has 1-cycle read.)
1. Reset held 3 cycles, then idle 70 cycles -> all outputs 0; slot_phase counts 0..31 and wraps twice.
2. doc_req=1, doc_addr=0x1234, RAM[0x1234]=0x5A -> ram_en for one cycle with addr 0x1234 after the phase-0 edge; doc_rvalid pulse with 0x5A two edges later; repeats each period.
3. Host write pulse at phase 3 (addr 0x00FF, data 0xA5), then host read of 0x00FF -> write strobe at the phase-16 edge, host_ack 2 edges later; read in the next period returns host_rdata=0xA5.
4. host_req captured at the phase-16 edge -> served at phase 16 of the next period, host_ack 34 clocks after the request; a second host_req meanwhile is ignored (exactly one ram_en).
5. Reset asserted at the edge after a host read issue -> no host_ack, host_busy=0, ram_en=0 next cycle.
6. SOUND_RAM_SLOT_STEAL_EN defined, doc_req=0, host read at phase 20 -> served at phase 0, none at phase 16; with doc_req=1 -> served at phase 16.
